alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (legal 8..64).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port ALUcontrol, input, 4, opcode, sampled on accept.
REQ-005 SHALL have port in1, input, WIDTH, operand A.
REQ-006 SHALL have port in2, input, WIDTH, operand B.
REQ-007 SHALL have port in_valid, input, 1, request present.
REQ-008 SHALL have port in_ready, output, 1, block can accept.
REQ-009 SHALL have port result, output, WIDTH, registered result.
REQ-010 SHALL have port zero, output, 1, result == 0.
REQ-011 SHALL have port ovf, output, 1, signed overflow (add/sub only, else 0).
REQ-012 SHALL have port out_valid, output, 1, result valid.
REQ-013 SHALL have port out_ready, input, 1, consumer takes result.

Function
REQ-014 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 unsigned less-than (1/0), 0011 signed less-than, 1000 MUL (low WIDTH bits), 1001 DIVU, 1010 REMU; any other code SHALL behave as AND.
REQ-015 States SHALL be IDLE, CALC, DONE; in_ready SHALL be 1 only in IDLE, out_valid 1 only in DONE.
REQ-016 Accept SHALL occur when in_valid && in_ready; operands and opcode SHALL be latched then and later input changes ignored.
REQ-017 Single-cycle ops SHALL go IDLE->DONE; accept at edge t, out_valid high after edge t+1 (latency 1).
REQ-018 MUL/DIVU/REMU SHALL go IDLE->CALC, iterate exactly WIDTH cycles (shift-add multiply, restoring divide, one bit per cycle), then CALC->DONE; out_valid high after edge t+WIDTH+1.
REQ-019 Iteration counter SHALL be $clog2(WIDTH+1) bits, loaded with WIDTH on accept, decremented per CALC cycle; CALC->DONE when it reaches 1 and is decremented.
REQ-020 DONE SHALL hold result/zero/ovf stable until out_ready; DONE && out_ready SHALL go to IDLE next edge (no same-cycle re-accept).
REQ-021 DIVU by zero SHALL yield all-ones; REMU by zero SHALL yield in1; both SHALL take full WIDTH cycles.
REQ-022 ADD/SUB SHALL wrap modulo 2^WIDTH; ovf SHALL be set on signed overflow; carry-out discarded.
REQ-023 zero and ovf SHALL be registered alongside result and update only on DONE entry.
REQ-024 in_valid while busy SHALL be ignored (request held by producer); out_ready while not DONE SHALL be ignored.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, result=0, zero=0, ovf=0, out_valid=0, counter=0.
REQ-026 in_ready SHALL be 1 during and after reset.
REQ-027 Reset mid-CALC or mid-DONE SHALL discard the operation with no output produced.

Structure
REQ-028 Opcode constants and the state encoding SHALL live in shared package alu_pkg, reused by control decode.
REQ-029 Iterative multiply/divide datapath SHALL be sub-module muldiv_iter (start, op, operands, done, result); single-cycle ops and FSM SHALL stay in alu_muldiv.
REQ-030 Implementation SHALL contain no latches and no combinational path from in_* to out_*.

Verification
REQ-031 WIDTH=32, ADD 0x7FFFFFFF+1, out_ready=1 -> out_valid 1 cycle after accept, result 0x80000000, ovf=1, zero=0.
REQ-032 SUB 5-5 -> result 0, zero=1, ovf=0; op 0011 with in1=0xFFFFFFFF, in2=1 -> 1; op 0111 same operands -> 0.
REQ-033 MUL 0x00010001 x 0x00010001 -> result 0x00020001, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
REQ-034 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
REQ-035 out_ready held 0 for 5 cycles in DONE -> result stable, in_valid ignored; then out_ready=1 -> IDLE next edge, in_ready=1.
REQ-036 rst_n low 10 cycles into MUL -> immediate IDLE, outputs 0, no out_valid pulse; next ADD 2+3 -> 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and iterative-op decode for the ALU/muldiv block.
package alu_pkg;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {MD_MUL, MD_DIVU, MD_REMU} mdop_t;

  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic mdop_t md_decode(input logic [3:0] op);
    case (op)
      OP_DIVU: return MD_DIVU;
      OP_REMU: return MD_REMU;
      default: return MD_MUL;
    endcase
  endfunction
endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider sharing one register set.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  mdop_t            op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH + 1);

  // x: accumulator / partial remainder, y: multiplicand / divisor, z: multiplier / quotient
  mdop_t            op_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] x, y, z;
  logic [WIDTH-1:0] x_nxt, y_nxt, z_nxt;
  logic [WIDTH:0]   r_sh, diff;

  always_comb begin
    r_sh  = {x, z[WIDTH-1]};
    diff  = r_sh - {1'b0, y};
    x_nxt = x;
    y_nxt = y;
    z_nxt = z;
    if (op_q == MD_MUL) begin
      x_nxt = x + (z[0] ? y : '0);
      y_nxt = y << 1;
      z_nxt = z >> 1;
    end else begin
      // no borrow means the divisor fits: keep the difference and shift in a 1
      x_nxt = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      z_nxt = {z[WIDTH-2:0], ~diff[WIDTH]};
    end
  end

  assign done = (cnt == CW'(1));

  always_comb begin
    case (op_q)
      MD_MUL:  result = x_nxt;
      MD_DIVU: result = z_nxt;
      default: result = x_nxt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      op_q <= MD_MUL;
      x    <= '0;
      y    <= '0;
      z    <= '0;
    end else if (start) begin
      cnt  <= CW'(WIDTH);
      op_q <= op;
      x    <= '0;
      y    <= (op == MD_MUL) ? a : b;
      z    <= (op == MD_MUL) ? b : a;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      x   <= x_nxt;
      y   <= y_nxt;
      z   <= z_nxt;
    end
  end
endmodule

// File: rtl/alu_muldiv.sv
// Handshaked ALU: logic/add/compare finish in one cycle, mul/div iterate via muldiv_iter.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ALUcontrol,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [1:0]       state;
  logic             accept;
  logic [WIDTH-1:0] alu_r, md_res;
  logic             alu_ovf, md_done;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    alu_r   = in1 & in2;
    alu_ovf = 1'b0;
    case (ALUcontrol)
      OP_OR:   alu_r = in1 | in2;
      OP_ADD: begin
        alu_r   = in1 + in2;
        alu_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (alu_r[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r   = in1 - in2;
        alu_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (alu_r[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SLTU: alu_r = WIDTH'(in1 < in2);
      OP_SLT:  alu_r = WIDTH'($signed(in1) < $signed(in2));
      default: alu_r = in1 & in2;
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && is_iter(ALUcontrol)),
    .op     (md_decode(ALUcontrol)),
    .a      (in1),
    .b      (in2),
    .done   (md_done),
    .result (md_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      result <= '0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          if (is_iter(ALUcontrol)) begin
            state <= S_CALC;
          end else begin
            state  <= S_DONE;
            result <= alu_r;
            zero   <= (alu_r == '0);
            ovf    <= alu_ovf;
          end
        end
        S_CALC: if (md_done) begin
          state  <= S_DONE;
          result <= md_res;
          zero   <= (md_res == '0);
          ovf    <= 1'b0;
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboarded bench: expectations from an operator-level model, compared on out_valid.
module tb_alu_muldiv;
  logic        clk, rst_n;
  logic [3:0]  ALUcontrol;
  logic [31:0] in1, in2, result;
  logic        in_valid, in_ready, zero, ovf, out_valid, out_ready;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        o;
    int          lat;
  } exp_t;
  exp_t sb[$];

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ALUcontrol(ALUcontrol), .in1(in1), .in2(in2),
    .in_valid(in_valid), .in_ready(in_ready), .result(result), .zero(zero),
    .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint s;
    e.o   = 0;
    e.lat = 1;
    case (op)
      4'b0001: e.res = a | b;
      4'b0010: begin
        s = longint'($signed(a)) + longint'($signed(b));
        e.res = a + b;
        e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s = longint'($signed(a)) - longint'($signed(b));
        e.res = a - b;
        e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: e.res = (a < b) ? 32'd1 : 32'd0;
      4'b0011: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: begin e.res = a * b; e.lat = 33; end
      4'b1001: begin e.res = (b == 0) ? 32'hFFFFFFFF : a / b; e.lat = 33; end
      4'b1010: begin e.res = (b == 0) ? a : a % b; e.lat = 33; end
      default: e.res = a & b;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // drive one request, count cycles to out_valid, then let the consumer take it
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic z, output logic o,
                        output int lat, output bit rdy_leak);
    sb.push_back(model(op, a, b));
    ALUcontrol = op; in1 = a; in2 = b; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0; in1 = $urandom; in2 = $urandom; ALUcontrol = 4'($urandom);
    lat = 1; rdy_leak = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_leak = 1;
      @(posedge clk); #1;
      lat++;
    end
    r = result; z = zero; o = ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 0; in_valid = 0; out_ready = 0; ALUcontrol = 0; in1 = 0; in2 = 0;
    #3;
    vectors++;
    if ({in_ready, out_valid, result, zero, ovf} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: rdy=%b vld=%b res=%h z=%b o=%b, want 1 0 0 0 0",
               in_ready, out_valid, result, zero, ovf);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_table(input string name, input logic [3:0] ops[], input logic [31:0] as[],
                            input logic [31:0] bs[]);
    logic [31:0] r; logic z, o; int lat; bit leak; exp_t e;
    for (int i = 0; i < ops.size(); i++) begin
      run_op(ops[i], as[i], bs[i], r, z, o, lat, leak);
      e = sb.pop_front();
      vectors++;
      if (r !== e.res || z !== e.z || o !== e.o || lat != e.lat || (e.lat > 1 && leak)) begin
        miscompares++;
        $display("FAIL %s[%0d] op=%b a=%h b=%h: res=%h z=%b o=%b lat=%0d leak=%b, want res=%h z=%b o=%b lat=%0d leak=0",
                 name, i, ops[i], as[i], bs[i], r, z, o, lat, leak, e.res, e.z, e.o, e.lat);
      end
    end
  endtask

  task automatic test_addsub;
    test_table("addsub", '{4'b0010, 4'b0110, 4'b0110, 4'b0010, 4'b0000, 4'b0001},
               '{32'h7FFFFFFF, 32'd5, 32'h80000000, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0},
               '{32'd1, 32'd5, 32'd1, 32'd1, 32'h0FF00FF0, 32'h0FF00FF0});
  endtask

  task automatic test_slt;
    test_table("slt", '{4'b0011, 4'b0111, 4'b0011, 4'b0111, 4'b1111},
               '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'd3, 32'h12345678},
               '{32'd1, 32'd1, 32'd3, 32'd4, 32'hFF00FF00});
  endtask

  task automatic test_mul;
    test_table("mul", '{4'b1000, 4'b1000, 4'b1000},
               '{32'h00010001, 32'hFFFFFFFF, 32'h12345678},
               '{32'h00010001, 32'hFFFFFFFF, 32'h0});
  endtask

  task automatic test_div;
    test_table("div", '{4'b1001, 4'b1010, 4'b1001, 4'b1010, 4'b1001, 4'b1010},
               '{32'd100, 32'd100, 32'd9, 32'd9, 32'hFFFFFFFF, 32'd6},
               '{32'd7, 32'd7, 32'd0, 32'd0, 32'd1, 32'd7});
  endtask

  task automatic test_backpressure;
    bit stable = 1;
    ALUcontrol = 4'b0010; in1 = 32'd10; in2 = 32'd20; in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || result !== 32'd30) begin
      miscompares++;
      $display("FAIL bp_first: vld=%b res=%h, want 1 0000001e", out_valid, result);
    end
    in1 = 32'd99; in2 = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd30) stable = 0;
    end
    vectors++;
    if (!stable) begin
      miscompares++;
      $display("FAIL bp_hold: vld=%b rdy=%b res=%h, want 1 0 0000001e", out_valid, in_ready, result);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midop;
    bit pulse = 0;
    logic [31:0] r; logic z, o; int lat; bit leak; exp_t e;
    ALUcontrol = 4'b1000; in1 = 32'hFFFF; in2 = 32'hFFFF; in_valid = 1; out_ready = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (10) @(posedge clk);
    #1 rst_n = 0;
    #1;
    vectors++;
    if ({in_ready, out_valid, result, zero, ovf} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_mid: rdy=%b vld=%b res=%h z=%b o=%b, want 1 0 0 0 0",
               in_ready, out_valid, result, zero, ovf);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulse = 1;
    end
    vectors++;
    if (pulse) begin
      miscompares++;
      $display("FAIL rst_mid_pulse: out_valid seen=1, want 0");
    end
    run_op(4'b0010, 32'd2, 32'd3, r, z, o, lat, leak);
    e = sb.pop_front();
    vectors++;
    if (r !== e.res || lat != e.lat) begin
      miscompares++;
      $display("FAIL rst_mid_add: res=%h lat=%0d, want %h %0d", r, lat, e.res, e.lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] ops[] = new[10];
    logic [31:0] as[] = new[10];
    logic [31:0] bs[] = new[10];
    logic [3:0] pick[8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0011, 4'b1000, 4'b1001};
    for (int i = 0; i < 10; i++) begin
      ops[i] = (i == 9) ? 4'b1010 : pick[$urandom_range(7)];
      as[i]  = $urandom;
      bs[i]  = (i % 3 == 0) ? 32'($urandom_range(255)) : $urandom;
    end
    test_table("b2b", ops, as, bs);
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_slt();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation bound reached");
    $fatal(1);
  end
endmodule
